// File: rtl/alu_pkg.sv
// Shared ALU definitions: field widths, the packed instruction word type and op codes.
package alu_pkg;

    localparam int CTRL_W = 3;
    localparam int OPND_W = 6;
    localparam int WORD_W = CTRL_W + 2 * OPND_W;

    // One ALU instruction word laid out as {control, A, B}, MSB first
    typedef logic [WORD_W-1:0] alu_word_t;

    // Op codes carried in the control field
    typedef enum logic [CTRL_W-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_PASS = 3'd7
    } alu_op_e;

endpackage

// File: rtl/alu_word_packer_sync_fifo.sv
// Small synchronous FIFO with an occupancy counter; the counter alone tells full from
// empty so the pointers can wrap naturally. Read data is forced to zero while empty.
module sync_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = 1;
    localparam logic [AW:0]   COUNT_FULL = DEPTH[AW:0];
    localparam logic [AW:0]   COUNT_ONE  = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == COUNT_FULL);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;

    // A push while full and a pop while empty are silently ignored
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Output word is the head entry; zero when nothing is buffered
    assign rdata   = empty ? '0 : mem[rd_ptr_reg];

    // Storage write: contents are never reset, only the pointers are
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointer and occupancy update; reset overrides any push or pop
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + COUNT_ONE;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - COUNT_ONE;
            end
        end
    end

endmodule

// File: rtl/alu_word_packer.sv
// Packs an op code and two operands into one ALU instruction word {control, A, B}
// and buffers the words in a small FIFO with valid/ready on both sides.
// Occupancy states (idle / partial / full) are read straight off the FIFO count.
module alu_word_packer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTRL_W-1:0]        control,
    input  logic [OPND_W-1:0]        A,
    input  logic [OPND_W-1:0]        B,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W-1:0]        data,
    output logic [$clog2(DEPTH):0]   count
);

    alu_word_t packed_word;
    logic      fifo_full;
    logic      fifo_empty;

    // Fixed bit order: control in the top bits, B in the bottom bits
    assign packed_word = {control, A, B};

    // Handshake flags come only from registered occupancy, never from in_valid/out_ready
    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (in_valid),
        .pop     (out_ready),
        .wdata   (packed_word),
        .rdata   (data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

endmodule

// File: tb/tb_alu_word_packer.sv
// Directed bench for alu_word_packer with a queue scoreboard of expected words.
module tb_alu_word_packer;
    import alu_pkg::*;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  control = '0;
    logic [5:0]  A = '0;
    logic [5:0]  B = '0;
    logic        in_ready;
    logic        out_valid;
    logic [14:0] data;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    logic [14:0] sb[$];
    logic [14:0] rx[$];
    logic        hold_pending = 1'b0;
    logic [14:0] held_word = '0;

    alu_word_packer #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .control   (control),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data      (data),
        .count     (count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, update the model at the edge
    task automatic cycle(input logic iv, input logic [2:0] c, input logic [5:0] a,
                         input logic [5:0] b, input logic ordy);
        logic do_push;
        logic do_pop;
        logic [14:0] head;
        in_valid  = iv;
        control   = c;
        A         = a;
        B         = b;
        out_ready = ordy;
        #1;
        head = (sb.size() != 0) ? sb[0] : 15'h0000;
        check("count", {13'd0, count}, 16'(sb.size()));
        check("out_valid", {15'd0, out_valid}, {15'd0, sb.size() != 0});
        check("in_ready", {15'd0, in_ready}, {15'd0, sb.size() != DEPTH});
        check("data", {1'b0, data}, {1'b0, head});
        if (hold_pending) check("hold", {1'b0, data}, {1'b0, held_word});
        hold_pending = (sb.size() != 0) && !ordy;
        held_word    = head;
        do_push = iv && (sb.size() < DEPTH);
        do_pop  = ordy && (sb.size() > 0);
        if (do_pop) rx.push_back(sb.pop_front());
        if (do_push) sb.push_back({c, a, b});
        $display("cycle iv=%0b word=%h ordy=%0b push=%0b pop=%0b data=%h count=%0d",
                 iv, {c, a, b}, ordy, do_push, do_pop, data, count);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic apply_reset();
        reset_n  = 1'b0;
        in_valid = 1'b1;
        control  = 3'b111;
        A        = 6'h00;
        B        = 6'h3F;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        hold_pending = 1'b0;
        #1;
        check("rst_count", {13'd0, count}, 16'd0);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check("rst_data", {1'b0, data}, 16'h0000);
        $display("reset count=%0d out_valid=%0b in_ready=%0b data=%h", count, out_valid, in_ready, data);
    endtask

    initial begin
        int idx;
        logic acc;
        logic [14:0] w;
        bit found;

        @(negedge clock);
        apply_reset();

        // Single word, latency and exact bit placement
        cycle(1'b1, 3'b101, 6'h2A, 6'h15, 1'b0);
        #1;
        check("single_data", {1'b0, data}, 16'h5A95);
        check("single_count", {13'd0, count}, 16'd1);
        check("single_valid", {15'd0, out_valid}, 16'd1);
        cycle(1'b0, 3'b000, 6'h00, 6'h00, 1'b1);
        cycle(1'b0, 3'b000, 6'h00, 6'h00, 1'b0);

        // Fill to full, then a dropped fifth word
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 3'(i + 1), 6'(i * 5 + 1), 6'(i * 7 + 2), 1'b0);
        cycle(1'b1, 3'b111, 6'h00, 6'h3F, 1'b0);
        #1;
        check("full_count", {13'd0, count}, 16'd4);
        check("full_in_ready", {15'd0, in_ready}, 16'd0);
        rx.delete();
        for (int i = 0; i < 5; i++) cycle(1'b0, 3'b000, 6'h00, 6'h00, 1'b1);
        check("fill_rx_count", 16'(rx.size()), 16'd4);
        check("fill_first", {1'b0, (rx.size() > 0) ? rx[0] : 15'h0}, 16'h1042);
        found = 1'b0;
        foreach (rx[k]) if (rx[k] == 15'h703F) found = 1'b1;
        check("fill_no_drop_word", {15'd0, found}, 16'd0);

        // Steady push+pop at count 2 across several pointer laps
        cycle(1'b1, 3'b010, 6'h11, 6'h22, 1'b0);
        cycle(1'b1, 3'b011, 6'h12, 6'h23, 1'b0);
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 3'(i), 6'(i + 32), 6'(63 - i), 1'b1);
        #1;
        check("sim_count", {13'd0, count}, 16'd2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'b000, 6'h00, 6'h00, 1'b1);

        // Back-pressure: 8 words with out_ready toggling
        rx.delete();
        idx = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (idx == 8 && sb.size() == 0) break;
            acc = (idx < 8) && (sb.size() < DEPTH);
            w = {3'(idx), 6'(idx * 9 + 3), 6'(idx * 4 + 1)};
            cycle(idx < 8, w[14:12], w[11:6], w[5:0], (cyc % 2) == 0);
            if (acc) idx++;
        end
        check("bp_rx_count", 16'(rx.size()), 16'd8);
        for (int k = 0; k < 8; k++) begin
            w = {3'(k), 6'(k * 9 + 3), 6'(k * 4 + 1)};
            check("bp_order", {1'b0, (k < rx.size()) ? rx[k] : 15'h0}, {1'b0, w});
        end

        // Reset mid-stream with three words buffered
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'b001, 6'(i), 6'(i), 1'b0);
        #1;
        check("pre_rst_count", {13'd0, count}, 16'd3);
        apply_reset();
        cycle(1'b1, 3'b111, 6'h00, 6'h3F, 1'b0);
        #1;
        check("post_rst_first", {1'b0, data}, 16'h703F);
        cycle(1'b0, 3'b000, 6'h00, 6'h00, 1'b1);
        cycle(1'b0, 3'b000, 6'h00, 6'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
